n64_joybus_rx: RTL

//  Parametrised Joybus (N64 controller) serial receiver; next-generation replacement for the fixed 32-bit reader.

---
 rtl/n64_pkg.sv | 19 +
 rtl/n64_line_sync.sv | 53 +++++
 rtl/n64_joybus_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/n64_pkg.sv
// Joybus shared definitions: FSM state encoding and error codes.
// Used by the receiver and the upcoming Joybus transmitter.
package n64_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LOW,
    S_HIGH,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_LOW_TOO_LONG = 2'b01;
  localparam logic [1:0] ERR_SHORT_FRAME  = 2'b10;
  localparam logic [1:0] ERR_NO_STOP      = 2'b11;

endpackage

// File: rtl/n64_line_sync.sv
// Joybus line synchroniser, optional glitch filter, edge pulses.
// Macro N64_RX_GLITCH_FILTER_EN enables the 3-cycle stability filter.
module n64_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic gpio_line,
  output logic line_s,
  output logic fall_p,
  output logic rise_p
);

  logic [1:0] sync_q;
  logic       prev_q;

  // two-flop synchroniser; line idles high
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], gpio_line};
  end

`ifdef N64_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // follow the line only after 3 equal samples in a row
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      if ({hist_q, sync_q[1]} == 3'b000)
        filt_q <= 1'b0;
      else if ({hist_q, sync_q[1]} == 3'b111)
        filt_q <= 1'b1;
    end
  end

  assign line_s = filt_q;
`else
  assign line_s = sync_q[1];
`endif

  // previous level for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= line_s;
  end

  assign fall_p = prev_q & ~line_s;
  assign rise_p = ~prev_q & line_s;

endmodule

// File: rtl/n64_joybus_rx.sv
// Joybus receiver: pulse-width bit decode, stop-bit check, typed errors.
// Optional macro N64_RX_GLITCH_FILTER_EN adds an input glitch filter.
module n64_joybus_rx #(
  parameter int NUM_BITS     = 32,
  parameter int CNT_W        = 10,
  parameter int BIT_THRESH   = 200,
  parameter int MAX_LOW      = 400,
  parameter int IDLE_TIMEOUT = 600
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                gpio_line,
  output logic                busy,
  output logic                data_valid,
  output logic [NUM_BITS-1:0] data,
  output logic                error,
  output logic [1:0]          err_code
);

  import n64_pkg::*;

  localparam int BC_W = $clog2(NUM_BITS + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [BC_W-1:0]  bcnt_t;

  localparam cnt_t  CNT_MAX  = '1;
  localparam cnt_t  CNT_ONE  = cnt_t'(1);
  localparam cnt_t  THRESH   = cnt_t'(BIT_THRESH);
  localparam cnt_t  LOW_LIM  = cnt_t'(MAX_LOW);
  localparam cnt_t  IDLE_LIM = cnt_t'(IDLE_TIMEOUT);
  localparam bcnt_t FULL     = bcnt_t'(NUM_BITS);

  if (IDLE_TIMEOUT + 1 > (2 ** CNT_W) - 1) begin : g_cnt_w_chk
    $error("CNT_W too narrow to count past IDLE_TIMEOUT");
  end
  if (NUM_BITS < 1 || NUM_BITS > 64) begin : g_bits_chk
    $error("NUM_BITS must be 1..64");
  end

  state_t        state_q, state_d;
  cnt_t          cnt_q, cnt_inc;
  bcnt_t         bit_cnt_q;
  logic [NUM_BITS-1:0] data_q;
  logic [1:0]    err_code_q;
  logic          line_s, fall_p, rise_p;
  logic          full, low_over, high_over;

  n64_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .gpio_line (gpio_line),
    .line_s    (line_s),
    .fall_p    (fall_p),
    .rise_p    (rise_p)
  );

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign full      = (bit_cnt_q == FULL);
  assign low_over  = (cnt_q > LOW_LIM);
  assign high_over = (cnt_q > IDLE_LIM) && line_s;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_ARMED;
      S_ARMED: if (fall_p) state_d = S_LOW;
      S_LOW: begin
        if (low_over)    state_d = S_ERR;
        else if (rise_p) state_d = full ? S_DONE : S_HIGH;
      end
      S_HIGH: begin
        if (fall_p)         state_d = S_LOW;
        else if (high_over) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy       = (state_q == S_ARMED) || (state_q == S_LOW) ||
                 (state_q == S_HIGH);
    data_valid = (state_q == S_DONE);
    error      = (state_q == S_ERR);
  end

  // pulse counter, bit counter, shift register, error code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            err_code_q <= ERR_NONE;
          end
        end
        S_ARMED: if (fall_p) cnt_q <= CNT_ONE;
        S_LOW: begin
          if (low_over) begin
            err_code_q <= ERR_LOW_TOO_LONG;
          end else if (rise_p && !full) begin
            data_q    <= (data_q << 1) |
                         NUM_BITS'(cnt_q < THRESH);
            bit_cnt_q <= bit_cnt_q + bcnt_t'(1);
            cnt_q     <= CNT_ONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_HIGH: begin
          if (fall_p)
            cnt_q <= CNT_ONE;
          else if (high_over)
            err_code_q <= full ? ERR_NO_STOP : ERR_SHORT_FRAME;
          else
            cnt_q <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign data     = data_q;
  assign err_code = err_code_q;

endmodule
